countdown_timer: RTL and testbench



---
 rtl/countdown_timer.sv | 130 +++++++++++++
 tb/tb_countdown_timer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer with an internal one-second prescaler.
// A preset 00-99 is loaded from switches (digits above 9 clamp to 9) and
// decremented once per tick down to 00, where the timer stops and flags expiry.
// Optional build macro COUNTDOWN_AUTO_RELOAD_EN: at 00 the digits reload from
// the preset register, done pulses and the timer keeps running (periodic mode).
module countdown_timer #(
   parameter int unsigned TICKS_PER_SEC = 50_000_000,
   parameter int unsigned PRESC_W       = 26
) (
   input  logic       fastclock,
   input  logic       clear,
   input  logic       load,
   input  logic [3:0] load_tens,
   input  logic [3:0] load_ones,
   input  logic       start,
   input  logic       pause,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       running,
   output logic       done,
   output logic       expired
);

   localparam logic [PRESC_W-1:0] PrescReload = PRESC_W'(TICKS_PER_SEC - 1);

   typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

   state_e             state_q;
   logic [3:0]         tens_q, ones_q;
   logic [PRESC_W-1:0] presc_q;
   logic               running_q, done_q, expired_q;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
   // Preset is only ever read back by the periodic reload.
   logic [3:0]         pre_tens_q, pre_ones_q;
`endif

   logic [3:0] clamp_tens, clamp_ones;
   logic [3:0] dec_tens, dec_ones;
   logic       count_zero, count_last, tick;

   // Clamp switch digits, BCD decrement with borrow, status decodes.
   always_comb begin
      clamp_tens = (load_tens > 4'd9) ? 4'd9 : load_tens;
      clamp_ones = (load_ones > 4'd9) ? 4'd9 : load_ones;
      dec_tens   = tens_q;
      dec_ones   = ones_q - 4'd1;
      if (ones_q == 4'd0) begin
         dec_ones = 4'd9;
         dec_tens = tens_q - 4'd1;
      end
      count_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
      count_last = (tens_q == 4'd0) && (ones_q == 4'd1);
      tick       = (presc_q == '0);
   end

   // Control FSM, prescaler and digit registers; every output is a register.
   always_ff @(posedge fastclock) begin
      if (clear) begin
         state_q    <= StIdle;
         tens_q     <= 4'd0;
         ones_q     <= 4'd0;
         presc_q    <= PrescReload;
         running_q  <= 1'b0;
         done_q     <= 1'b0;
         expired_q  <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
         pre_tens_q <= 4'd0;
         pre_ones_q <= 4'd0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StRun: begin
               // Pause first; a terminal tick below overrides it.
               if (pause) begin
                  state_q   <= StPause;
                  running_q <= 1'b0;
               end
               if (tick) begin
                  presc_q <= PrescReload;
                  if (count_last) begin
                     done_q <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                     tens_q <= pre_tens_q;
                     ones_q <= pre_ones_q;
`else
                     tens_q    <= 4'd0;
                     ones_q    <= 4'd0;
                     state_q   <= StDone;
                     running_q <= 1'b0;
                     expired_q <= 1'b1;
`endif
                  end else begin
                     tens_q <= dec_tens;
                     ones_q <= dec_ones;
                  end
               end else begin
                  presc_q <= presc_q - 1'b1;
               end
            end
            default: begin
               // IDLE, PAUSE, DONE: load has priority over start.
               if (load) begin
                  tens_q     <= clamp_tens;
                  ones_q     <= clamp_ones;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                  pre_tens_q <= clamp_tens;
                  pre_ones_q <= clamp_ones;
`endif
                  state_q    <= StIdle;
                  expired_q  <= 1'b0;
                  presc_q    <= PrescReload;
               end else if (start && (state_q != StDone) && !count_zero) begin
                  // Resuming from PAUSE keeps the partial second.
                  if (state_q == StIdle) presc_q <= PrescReload;
                  state_q   <= StRun;
                  running_q <= 1'b1;
               end
            end
         endcase
      end
   end

   assign tens    = tens_q;
   assign ones    = ones_q;
   assign running = running_q;
   assign done    = done_q;
   assign expired = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: decimal-valued reference model checked every
// cycle, plus hand-computed expectations at key points of the test plan.
module tb_countdown_timer;

   localparam int T = 4;

   logic       fastclock = 1'b0;
   logic       clear = 1'b1, load = 1'b0, start = 1'b0, pause = 1'b0;
   logic [3:0] load_tens = 4'd0, load_ones = 4'd0;
   logic [3:0] tens, ones;
   logic       running, done, expired;

   countdown_timer #(.TICKS_PER_SEC(T), .PRESC_W(3)) dut (
      .fastclock(fastclock), .clear(clear), .load(load),
      .load_tens(load_tens), .load_ones(load_ones),
      .start(start), .pause(pause),
      .tens(tens), .ones(ones), .running(running), .done(done), .expired(expired)
   );

   always #5 fastclock = ~fastclock;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // Model: count as a plain number, rem = cycles left until the next decrement.
   localparam int MIdle = 0, MRun = 1, MPause = 2, MDone = 3;
   int m_count = 0, m_preset = 0, m_rem = T, m_mode = MIdle;
   bit m_done = 1'b0, m_exp = 1'b0;

   function automatic int min9(input logic [3:0] d);
      return (d > 4'd9) ? 9 : int'(d);
   endfunction

   always @(posedge fastclock) begin
      chk_en <= 1'b1;
      if (clear) begin
         m_count = 0; m_preset = 0; m_rem = T; m_mode = MIdle; m_done = 0; m_exp = 0;
      end else begin
         m_done = 0;
         if (m_mode != MRun && load) begin
            m_count  = min9(load_tens) * 10 + min9(load_ones);
            m_preset = m_count;
            m_mode   = MIdle;
            m_exp    = 0;
            m_rem    = T;
         end else if ((m_mode == MIdle || m_mode == MPause) && start && m_count != 0) begin
            if (m_mode == MIdle) m_rem = T;
            m_mode = MRun;
         end else if (m_mode == MRun) begin
            if (pause) m_mode = MPause;
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
               m_rem   = T;
               m_count = m_count - 1;
               if (m_count == 0) begin
                  m_done = 1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                  m_count = m_preset;
`else
                  m_mode = MDone;
                  m_exp  = 1;
`endif
               end
            end
         end
      end
   end

   function automatic logic [10:0] dut_vec();
      return {tens, ones, running, done, expired};
   endfunction

   function automatic logic [10:0] model_vec();
      logic [3:0] t, o;
      t = 4'(m_count / 10);
      o = 4'(m_count % 10);
      return {t, o, (m_mode == MRun), m_done, m_exp};
   endfunction

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge fastclock) begin
      if (chk_en) begin
         n_vec++;
         if (dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL cycle t=%0t got {tens,ones,run,done,exp}=%b required %b",
                     $time, dut_vec(), model_vec());
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge fastclock);
   endtask

   task automatic check(input string name, input logic [10:0] exp);
      n_vec++;
      if (dut_vec() !== exp) begin
         n_err++;
         $display("FAIL %s got {tens,ones,run,done,exp}=%b required %b", name, dut_vec(), exp);
      end
   endtask

   task automatic do_load(input logic [3:0] t, input logic [3:0] o);
      load = 1'b1; load_tens = t; load_ones = o;
      cyc(1);
      load = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   initial begin
      // Reset
      cyc(2);
      check("reset", 11'b0);
      clear = 1'b0;

      // Basic countdown 12 -> 00
      do_load(4'h1, 4'h2);
      check("load12", {4'd1, 4'd2, 3'b000});
      do_start();
      check("run12", {4'd1, 4'd2, 3'b100});
      cyc(4); check("tick11", {4'd1, 4'd1, 3'b100});
      cyc(4); check("tick10", {4'd1, 4'd0, 3'b100});
      cyc(4); check("borrow09", {4'd0, 4'd9, 3'b100});
      cyc(36);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      check("terminal", {4'd1, 4'd2, 3'b110});
      cyc(1); check("after_term", {4'd1, 4'd2, 3'b100});
`else
      check("terminal", {4'd0, 4'd0, 3'b011});
      cyc(1); check("after_term", {4'd0, 4'd0, 3'b001});
      cyc(5); check("hold00", {4'd0, 4'd0, 3'b001});
`endif
      clear = 1'b1; cyc(1); clear = 1'b0;

      // Clamp, start at 00 ignored, load during RUN ignored
      do_load(4'hC, 4'hF);
      check("clamp99", {4'd9, 4'd9, 3'b000});
      do_load(4'h0, 4'h0);
      do_start();
      check("start00", {4'd0, 4'd0, 3'b000});
      do_load(4'h0, 4'h5);
      do_start();
      check("run05", {4'd0, 4'd5, 3'b100});
      load = 1'b1; load_tens = 4'h3; load_ones = 4'h3;
      cyc(2);
      load = 1'b0;
      check("load_in_run", {4'd0, 4'd5, 3'b100});

      // Pause and resume with retained prescaler
      cyc(2); check("tick04", {4'd0, 4'd4, 3'b100});
      cyc(1);
      pause = 1'b1; cyc(1); pause = 1'b0;
      check("paused", {4'd0, 4'd4, 3'b000});
      cyc(10); check("frozen", {4'd0, 4'd4, 3'b000});
      do_start();
      check("resumed", {4'd0, 4'd4, 3'b100});
      cyc(1); check("resume+1", {4'd0, 4'd4, 3'b100});
      cyc(1); check("resume+2", {4'd0, 4'd3, 3'b100});

      // Pause coincident with terminal tick
      cyc(8); check("at01", {4'd0, 4'd1, 3'b100});
      cyc(3);
      pause = 1'b1; cyc(1); pause = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      check("pause_term", {4'd0, 4'd5, 3'b010});
`else
      check("pause_term", {4'd0, 4'd0, 3'b011});
`endif
      do_load(4'h0, 4'h3);
      check("reload03", {4'd0, 4'd3, 3'b000});

      // Mid-run clear
      do_load(4'h0, 4'h7);
      do_start();
      cyc(2); check("run07", {4'd0, 4'd7, 3'b100});
      clear = 1'b1; cyc(1); clear = 1'b0;
      check("midclear", 11'b0);

      // Preset 03 through terminal
      do_load(4'h0, 4'h3);
      do_start();
      cyc(4); check("p02", {4'd0, 4'd2, 3'b100});
      cyc(4); check("p01", {4'd0, 4'd1, 3'b100});
      cyc(4);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      check("p_reload", {4'd0, 4'd3, 3'b110});
`else
      check("p_done", {4'd0, 4'd0, 3'b011});
`endif
      cyc(6);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
